ffs_burst_arbiter: RTL and testbench

Round-robin arbiter that hands a shared resource to one of CLIENTS requesters for a whole multi-beat burst rather than a single cycle. It uses the same descending find-first-set priority scheme as the single-cycle arbiter. The block latches each winner's burst length, holds the grant until the resource has accepted that many beats, then re-arbitrates. It sits between the client request logic and the shared resource's beat-acceptance handshake.

---
 rtl/ffs_burst_arbiter.sv | 132 +++++++++++++
 tb/tb_ffs_burst_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ffs_burst_arbiter.sv
// Burst round-robin arbiter: descending find-first-set over requests masked below the
// previous winner; holds each grant for req_len+1 accepted beats. Optional watchdog: ARB_TIMEOUT_EN.
module ffs_burst_arbiter #(
    parameter int unsigned CLIENTS        = 8,
    parameter int unsigned LEN_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CLIENTS-1:0]         req,
    input  logic [CLIENTS*LEN_W-1:0]   req_len,
    input  logic                       beat,
    output logic [CLIENTS-1:0]         gnt,
    output logic [$clog2(CLIENTS)-1:0] gnt_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned ID_W = $clog2(CLIENTS);

    if (CLIENTS < 2 || CLIENTS > 16) begin : g_bad_clients
        $error("ffs_burst_arbiter: CLIENTS must be 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ffs_burst_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [CLIENTS-1:0] gnt_d;
    logic [ID_W-1:0]    gnt_id_d;
    logic [CLIENTS-1:0] mask_q, mask_d;
    logic [CLIENTS-1:0] masked;
    logic [ID_W-1:0]    win_id;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               abort;

    // Ascending scan so the last hit, i.e. the highest set index, wins.
    always_comb begin
        masked = req & mask_q;
        win_id = '0;
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            if ((|masked) ? masked[i] : req[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt;
        gnt_id_d = gnt_id;
        mask_d   = mask_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = BURST;
                    gnt_d    = CLIENTS'(1) << win_id;
                    gnt_id_d = win_id;
                    mask_d   = (CLIENTS'(1) << win_id) - CLIENTS'(1);
                    len_d    = req_len[win_id*LEN_W +: LEN_W];
                    cnt_d    = '0;
                end
            end
            BURST: begin
                if (abort || (beat && cnt_q == len_q)) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end else if (beat) begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            mask_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = |gnt;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    assign abort = (state_q == BURST) && (wd_q == WD_W'(TIMEOUT_CYCLES));

    always_comb begin
        wd_d = wd_q;
        if (state_q != BURST || beat || abort) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q        <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            timeout_err <= abort;
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ffs_burst_arbiter.sv
// Directed bench for ffs_burst_arbiter: reset, rotation, burst length, request drop,
// wrap/single requester and watchdog (ARB_TIMEOUT_EN) or indefinite hold.
module tb_ffs_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req;
    logic [31:0] req_len;
    logic        beat;
    logic [7:0]  gnt;
    logic [2:0]  gnt_id;
    logic        busy;
    logic        timeout_err;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    ffs_burst_arbiter #(
        .CLIENTS(8),
        .LEN_W(4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_len(req_len),
        .beat(beat),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h00);
        chk({tag, "_id"}, 32'(gnt_id), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_terr"}, 32'(timeout_err), 32'h0);
    endtask

    logic [7:0] rot_exp [9];

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        req_len = '0;
        beat    = 1'b0;
        step();
        step();
        chk_idle("por");
        rst_n = 1'b1;

        // First pick after reset: highest index. Async reset mid-burst clears all.
        req            = 8'hFF;
        req_len[28+:4] = 4'd3;
        step();
        chk("rst_first_gnt", 32'(gnt), 32'h80);
        chk("rst_first_id", 32'(gnt_id), 32'h7);
        chk("rst_first_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'h80);
        req  = 8'h00;
        beat = 1'b1;
        step();
        chk("c7_b1", 32'(gnt), 32'h80);
        step();
        step();
        chk("c7_b3", 32'(gnt), 32'h80);
        step();
        chk("c7_done", 32'(gnt), 32'h00);

        // Rotation, last = 7, single-beat bursts, beat held high.
        req_len = '0;
        req     = 8'hA5;
        rot_exp = '{8'h20, 8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00, 8'h20};
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("rot_%0d", i), 32'(gnt), 32'(rot_exp[i]));
        end
        chk("rot_id", 32'(gnt_id), 32'h5);
        req = 8'h00;
        step();
        chk("rot_end", 32'(gnt), 32'h00);
        beat = 1'b0;
        step();

        // Client 3 alone, 6 beats on alternate cycles.
        req_len[12+:4] = 4'd5;
        req            = 8'h08;
        step();
        req = 8'h00;
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("len_c%0d", k), 32'(gnt), 32'h08);
            beat = (k % 2 == 0);
            step();
        end
        chk("len_release", 32'(gnt), 32'h00);
        beat = 1'b0;

        // Client 5 drops req after one beat; burst of 4 still completes.
        req_len[20+:4] = 4'd3;
        req            = 8'h20;
        step();
        chk("drop_gnt", 32'(gnt), 32'h20);
        beat = 1'b1;
        step();
        chk("drop_b1", 32'(gnt), 32'h20);
        req  = 8'h00;
        beat = 1'b0;
        step();
        chk("drop_hold", 32'(gnt), 32'h20);
        beat = 1'b1;
        step();
        step();
        chk("drop_b3", 32'(gnt), 32'h20);
        step();
        chk("drop_done", 32'(gnt), 32'h00);
        beat = 1'b0;

        // Wrap: client 0 wins, is re-granted alone; beat in IDLE ignored; then 7 wins.
        req_len[0+:4] = 4'd1;
        req           = 8'h01;
        step();
        chk("wrap_gnt", 32'(gnt), 32'h01);
        beat = 1'b1;
        step();
        chk("wrap_b1", 32'(gnt), 32'h01);
        step();
        chk("wrap_idle", 32'(gnt), 32'h00);
        step();
        chk("single_regnt", 32'(gnt), 32'h01);
        req = 8'h81;
        step();
        chk("single_b1", 32'(gnt), 32'h01);
        step();
        chk("single_done", 32'(gnt), 32'h00);
        step();
        chk("wrap7_gnt", 32'(gnt), 32'h80);
        chk("wrap7_id", 32'(gnt_id), 32'h7);
        req = 8'h00;
        step();
        chk("wrap7_done", 32'(gnt), 32'h00);
        beat = 1'b0;

        // Grantee sends no beats.
        req = 8'h10;
        step();
        chk("to_gnt", 32'(gnt), 32'h10);
        req = 8'h00;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("to_hold_%0d", k), 32'(gnt), 32'h10);
            chk($sformatf("to_noerr_%0d", k), 32'(timeout_err), 32'h0);
        end
        step();
        chk("to_abort_gnt", 32'(gnt), 32'h00);
        chk("to_abort_err", 32'(timeout_err), 32'h1);
        step();
        chk("to_err_pulse", 32'(timeout_err), 32'h0);
        chk("to_stay_idle", 32'(gnt), 32'h00);
`else
        for (int k = 1; k <= 100; k++) begin
            step();
            if (gnt !== 8'h10 || timeout_err !== 1'b0 || k == 100) begin
                chk($sformatf("hold_%0d", k), {23'd0, timeout_err, gnt}, 32'h10);
            end
        end
        beat = 1'b1;
        step();
        chk("hold_release", 32'(gnt), 32'h00);
        beat = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
